// File: rtl/m_arbiter_port.sv
`default_nettype none
// ============================================================================
//  Module   : m_arbiter_port
//  Purpose  : Master-side port of a serial bus arbiter. Serialises bus
//             requests and accept/reject answers towards the arbiter. Decodes
//             2-bit codes sent by the arbiter: GRANT, RESUME, GO and the two
//             STOP codes. Hands a timed accept/reject decision to the local
//             master core.
//  Ports    : clk, rstN           - clock, async active-low reset
//             arb_in / arb_out    - serial lines from / to the arbiter
//             req, slave_id       - core bus request and target slave
//             accept, reject      - core decision while granted
//             done_i, resume_rdy  - transfer finished / ready after a stop
//             granted, resumed    - decision window open / grant was RESUME
//             com_active          - transfer in progress
//             split, preempted    - stopped by arbiter (reason)
//             busy                - port not idle
//  Revision : 1.0 - initial release
// ============================================================================
module m_arbiter_port #(
  parameter int NO_SLAVES   = 3,
  parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  arb_in,
  output logic                  arb_out,
  input  logic                  req,
  input  logic [S_ID_WIDTH-1:0] slave_id,
  input  logic                  accept,
  input  logic                  reject,
  input  logic                  done_i,
  input  logic                  resume_rdy,
  output logic                  granted,
  output logic                  resumed,
  output logic                  com_active,
  output logic                  split,
  output logic                  preempted,
  output logic                  busy
);

  // Bits still to send after the first one of the longest (REQUEST) frame.
  localparam int SH_W  = S_ID_WIDTH + 2;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_REQ   = CNT_W'(SH_W);
  localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(2);

  // Received codes
  localparam logic [1:0] CODE_GRANT  = 2'b11;
  localparam logic [1:0] CODE_RESUME = 2'b10;
  localparam logic [1:0] CODE_GO     = 2'b11;
  localparam logic [1:0] CODE_SPLIT  = 2'b10;
  localparam logic [1:0] CODE_PREEMP = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_REQ_TX     = 4'd1,
    ST_WAIT_GRANT = 4'd2,
    ST_DECIDE     = 4'd3,
    ST_ACK_TX     = 4'd4,
    ST_NAK_TX     = 4'd5,
    ST_WAIT_GO    = 4'd6,
    ST_COM        = 4'd7,
    ST_OVER_TX    = 4'd8,
    ST_HOLD       = 4'd9,
    ST_DONE_TX    = 4'd10
  } state_t;

  // --------------------------------------------------------------------------
  // RX shifter: start bit, then code[1], then code[0]. The valid pulse
  // appears the cycle after code[0]; the shifter is already idle in that
  // cycle and can take the next start bit.
  // --------------------------------------------------------------------------
  logic [1:0] rx_cnt_q;
  logic [1:0] rx_code_q;
  logic       rx_valid_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_cnt_q   <= 2'd0;
      rx_code_q  <= 2'b00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_cnt_q)
        2'd0: begin
          if (arb_in) rx_cnt_q <= 2'd1;
        end
        2'd1: begin
          rx_code_q[1] <= arb_in;
          rx_cnt_q     <= 2'd2;
        end
        2'd2: begin
          rx_code_q[0] <= arb_in;
          rx_valid_q   <= 1'b1;
          rx_cnt_q     <= 2'd0;
        end
        default: rx_cnt_q <= 2'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM state, TX shifter, decision timeout and registered outputs
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [SH_W-1:0]   tx_shift_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              arb_out_q;
  logic              granted_q, resumed_q, com_active_q;
  logic              split_q, preempted_q, busy_q;

  logic              resumed_d, split_d, preempted_d;
  logic              tx_load;
  logic [SH_W-1:0]   tx_rest;
  logic [CNT_W-1:0]  tx_len;
  logic              tx_done;

  // Every frame starts with a 1; that bit is driven on the loading edge and
  // the shifter holds what is left.
  assign tx_done = (tx_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    resumed_d   = resumed_q;
    split_d     = split_q;
    preempted_d = preempted_q;
    tx_load     = 1'b0;
    tx_rest     = '0;
    tx_len      = '0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_REQ_TX;
          tx_load = 1'b1;
          tx_rest = {2'b11, slave_id};
          tx_len  = CNT_REQ;
        end
      end
      ST_REQ_TX: begin
        if (tx_done) state_d = ST_WAIT_GRANT;
      end
      ST_WAIT_GRANT: begin
        if (rx_valid_q && rx_code_q == CODE_GRANT) begin
          state_d   = ST_DECIDE;
          resumed_d = 1'b0;
        end else if (rx_valid_q && rx_code_q == CODE_RESUME) begin
          state_d   = ST_DECIDE;
          resumed_d = 1'b1;
        end
      end
      ST_DECIDE: begin
        // A simultaneous accept and reject is treated as a reject.
        if (accept && !reject) begin
          state_d = ST_ACK_TX;
          tx_load = 1'b1;
          tx_rest = {2'b01, {S_ID_WIDTH{1'b0}}};
          tx_len  = CNT_SHORT;
        end else if (reject || to_cnt_q == TO_LAST) begin
          state_d = ST_NAK_TX;
          tx_load = 1'b1;
          tx_rest = {2'b10, {S_ID_WIDTH{1'b0}}};
          tx_len  = CNT_SHORT;
        end
      end
      ST_ACK_TX: begin
        if (tx_done) state_d = ST_WAIT_GO;
      end
      ST_NAK_TX: begin
        if (tx_done) state_d = ST_IDLE;
      end
      ST_WAIT_GO: begin
        if (rx_valid_q && rx_code_q == CODE_GO) state_d = ST_COM;
      end
      ST_COM: begin
        // A stop takes priority; a coincident done_i is dropped.
        if (rx_valid_q && rx_code_q == CODE_SPLIT) begin
          state_d = ST_HOLD;
          split_d = 1'b1;
        end else if (rx_valid_q && rx_code_q == CODE_PREEMP) begin
          state_d     = ST_HOLD;
          preempted_d = 1'b1;
        end else if (done_i) begin
          state_d = ST_OVER_TX;
          tx_load = 1'b1;
        end
      end
      ST_OVER_TX: begin
        if (tx_done) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (resume_rdy) begin
          state_d = ST_DONE_TX;
          tx_load = 1'b1;
        end
      end
      ST_DONE_TX: begin
        if (tx_done) state_d = ST_WAIT_GRANT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != ST_HOLD) begin
      split_d     = 1'b0;
      preempted_d = 1'b0;
    end
    if (state_d == ST_IDLE) resumed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      to_cnt_q     <= '0;
      arb_out_q    <= 1'b0;
      granted_q    <= 1'b0;
      resumed_q    <= 1'b0;
      com_active_q <= 1'b0;
      split_q      <= 1'b0;
      preempted_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (tx_load) begin
        arb_out_q  <= 1'b1;
        tx_shift_q <= tx_rest;
        tx_cnt_q   <= tx_len;
      end else if (!tx_done) begin
        arb_out_q  <= tx_shift_q[SH_W-1];
        tx_shift_q <= {tx_shift_q[SH_W-2:0], 1'b0};
        tx_cnt_q   <= tx_cnt_q - CNT_W'(1);
      end else begin
        arb_out_q  <= 1'b0;
      end

      // Counts DECIDE cycles; zero on the first cycle of each window.
      if (state_q == ST_DECIDE && state_d == ST_DECIDE) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_q <= '0;
      end

      granted_q    <= (state_d == ST_DECIDE);
      com_active_q <= (state_d == ST_COM);
      busy_q       <= (state_d != ST_IDLE);
      resumed_q    <= resumed_d;
      split_q      <= split_d;
      preempted_q  <= preempted_d;
    end
  end

  assign arb_out    = arb_out_q;
  assign granted    = granted_q;
  assign resumed    = resumed_q;
  assign com_active = com_active_q;
  assign split      = split_q;
  assign preempted  = preempted_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
